// File: rtl/sync_mem_responder.sv
// rtl/sync_mem_responder.sv - single-port word memory behind a three-state request/ready handshake
// Optional protocol checker driving err_flags: define SYNC_MEM_PROTO_CHECK_EN.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef HART_ID_W
`define HART_ID_W 4
`endif

module sync_mem_responder #(
    parameter int DEPTH_WORDS = 512,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [`ADDR_W-1:0]    mem_addr,
    input  logic [`XLEN-1:0]      mem_wdata,
    input  logic [`HART_ID_W-1:0] mem_tag,
    output logic [`XLEN-1:0]      mem_rdata,
    output logic                  mem_ready,
    output logic [`HART_ID_W-1:0] mem_rtag,
    output logic                  busy,
    output logic [2:0]            err_flags
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t               state;
    logic [`ADDR_W-1:0]   addr_q;
    logic                 we_q;
    logic [`XLEN-1:0]     wdata_q;
    logic [`XLEN-1:0]     mem_array [DEPTH_WORDS];

    logic [IDX_W-1:0]     idx;
    logic                 in_range;
    logic                 do_write;
    logic                 unused_bits;

    assign idx         = addr_q[IDX_W+1:2];
    assign in_range    = ~|addr_q[`ADDR_W-1:IDX_W+2];
    assign unused_bits = ^addr_q[1:0];

    // Gated by the live request so a withdrawn requester never sees a stale strobe.
    assign mem_ready = (state == RESP) && mem_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            mem_rdata <= '0;
            mem_rtag  <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        addr_q   <= mem_addr;
                        we_q     <= mem_we;
                        wdata_q  <= mem_wdata;
                        mem_rtag <= mem_tag;
                        state    <= ACCESS;
                        busy     <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (mem_req) begin
                        if (!we_q) begin
                            mem_rdata <= in_range ? mem_array[idx] : '0;
                        end
                        state <= RESP;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; rst still blocks a write pending in ACCESS.
    assign do_write = (state == ACCESS) && mem_req && we_q && in_range && !rst;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_array[idx] <= wdata_q;
        end
    end

`ifdef SYNC_MEM_PROTO_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flags <= '0;
        end else begin
            if ((state == ACCESS) && !mem_req) begin
                err_flags[0] <= 1'b1;
            end
            if (((state == ACCESS) || (state == RESP)) && mem_req &&
                ((mem_addr != addr_q) || (mem_we != we_q) ||
                 (mem_wdata != wdata_q) || (mem_tag != mem_rtag))) begin
                err_flags[1] <= 1'b1;
            end
            if ((state == ACCESS) && mem_req && !in_range) begin
                err_flags[2] <= 1'b1;
            end
        end
    end
`else
    assign err_flags = '0;
`endif

endmodule

// File: tb/tb_sync_mem_responder.sv
// tb/tb_sync_mem_responder.sv - directed self-checking bench for sync_mem_responder

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef HART_ID_W
`define HART_ID_W 4
`endif

module tb_sync_mem_responder;

`ifdef SYNC_MEM_PROTO_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  mem_req;
    logic                  mem_we;
    logic [`ADDR_W-1:0]    mem_addr;
    logic [`XLEN-1:0]      mem_wdata;
    logic [`HART_ID_W-1:0] mem_tag;
    logic [`XLEN-1:0]      mem_rdata;
    logic                  mem_ready;
    logic [`HART_ID_W-1:0] mem_rtag;
    logic                  busy;
    logic [2:0]            err_flags;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd;
    logic [31:0] rt;

    sync_mem_responder #(.DEPTH_WORDS(512)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_tag   (mem_tag),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_rtag  (mem_rtag),
        .busy      (busy),
        .err_flags (err_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full handshake: present at a negedge, expect ready two samples later, accept, drop.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] t,
                          output logic [31:0] rdata, output logic [31:0] rtag);
        int cnt = 0;
        @(negedge clk);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_tag   = t;
        do begin
            @(negedge clk);
            cnt++;
        end while (!mem_ready && cnt < 10);
        check({tag, "_latency"}, 32'(cnt), 32'd2);
        rdata = mem_rdata;
        rtag  = 32'(mem_rtag);
        @(posedge clk);
        #1 mem_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_tag = '0;
        #3;
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_rtag",  32'(mem_rtag), 32'h0);
        check("rst_ready", 32'(mem_ready), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_err",   32'(err_flags), 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Basic write then read with tag echo
        do_req("wr300", 1'b1, 32'h300, 32'h11111111, 4'd0, rd, rt);
        do_req("rd300", 1'b0, 32'h300, 32'h0, 4'd1, rd, rt);
        check("rd300_data", rd, 32'h11111111);
        check("rd300_tag",  rt, 32'd1);

        // Request held continuously: one pulse per three cycles
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_tag = 4'd1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("hold_ready_%0d", i), 32'(mem_ready), (i % 3 == 1) ? 32'd1 : 32'd0);
            check($sformatf("hold_busy_%0d", i),  32'(busy),      (i % 3 != 2) ? 32'd1 : 32'd0);
        end
        mem_req = 1'b0;

        // Dropped write in ACCESS
        do_req("wr000", 1'b1, 32'h000, 32'hA5A5A5A5, 4'd0, rd, rt);
        do_req("wr100", 1'b1, 32'h100, 32'h22222222, 4'd0, rd, rt);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'h99999999;
        @(posedge clk);
        #1 mem_req = 1'b0;
        @(negedge clk);
        check("drop_busy_access", 32'(busy), 32'd1);
        @(negedge clk);
        check("drop_busy_idle", 32'(busy), 32'd0);
        check("drop_err", 32'(err_flags), CHK ? 32'd1 : 32'd0);
        check("drop_rdata_kept", mem_rdata, 32'h11111111);
        do_req("rd100", 1'b0, 32'h100, 32'h0, 4'd2, rd, rt);
        check("drop_word_kept", rd, 32'h22222222);

        // Out-of-range read and write
        do_req("rd800", 1'b0, 32'h800, 32'h0, 4'd0, rd, rt);
        check("oor_rdata", rd, 32'h0);
        check("oor_err", 32'(err_flags), CHK ? 32'd5 : 32'd0);
        do_req("wr800", 1'b1, 32'h800, 32'h55555555, 4'd0, rd, rt);
        do_req("rd000", 1'b0, 32'h000, 32'h0, 4'd0, rd, rt);
        check("oor_word0_kept", rd, 32'hA5A5A5A5);
        do_req("rd100b", 1'b0, 32'h100, 32'h0, 4'd0, rd, rt);
        check("oor_word100_kept", rd, 32'h22222222);

        // Reset in ACCESS of a pending write
        do_req("wr204", 1'b1, 32'h204, 32'h12345678, 4'd3, rd, rt);
        do_req("rd204", 1'b0, 32'h204, 32'h0, 4'd3, rd, rt);
        check("rd204_data", rd, 32'h12345678);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h204; mem_wdata = 32'hDEADBEEF; mem_tag = 4'd3;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1; mem_req = 1'b0;
        #1;
        check("rstmid_rdata", mem_rdata, 32'h0);
        check("rstmid_rtag",  32'(mem_rtag), 32'h0);
        check("rstmid_busy",  32'(busy), 32'h0);
        check("rstmid_err",   32'(err_flags), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_rdata", mem_rdata, 32'h0);
        check("postrst_ready", 32'(mem_ready), 32'h0);
        do_req("rd204b", 1'b0, 32'h204, 32'h0, 4'd0, rd, rt);
        check("rstmid_word_kept", rd, 32'h12345678);

        // Ready gated by mem_req while in RESP
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h204; mem_tag = 4'd0;
        @(negedge clk); @(negedge clk);
        check("gate_ready_high", 32'(mem_ready), 32'd1);
        mem_req = 1'b0;
        #1;
        check("gate_ready_low", 32'(mem_ready), 32'd0);
        check("gate_busy", 32'(busy), 32'd1);
        check("gate_err", 32'(err_flags), 32'h0);

        // Address changed during RESP
        do_req("wr200", 1'b1, 32'h200, 32'h0BADF00D, 4'd2, rd, rt);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_tag = 4'd2;
        @(negedge clk); @(negedge clk);
        check("chg_ready", 32'(mem_ready), 32'd1);
        check("chg_rdata", mem_rdata, 32'h0BADF00D);
        mem_addr = 32'h204;
        @(posedge clk);
        #1 mem_req = 1'b0;
        @(negedge clk);
        check("chg_err", 32'(err_flags), CHK ? 32'd2 : 32'd0);
        check("chg_rdata_after", mem_rdata, 32'h0BADF00D);
        check("chg_rtag", 32'(mem_rtag), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
